// File: rtl/fifo_buffer_pkg.sv
// Shared constants, pointer-width helper and flit type for the fifo_buffer slice.
// The optional error flags (macro FIFO_BUFFER_ERR_FLAGS_EN) need nothing from this package.
package fifo_buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] flit_t;

    // A 1-bit pointer is still needed for a 2-entry queue.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_buffer_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one asynchronous read port.
// Contents are never reset; occupancy tracking in the parent decides what is valid.
module fifo_buffer_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock flit FIFO for a NoC input port, with global enable freeze.
// Define FIFO_BUFFER_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             empty,
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full
);

    localparam int          PW       = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [WIDTH-1:0] rd_word;
    logic             push;
    logic             pop;

    // Acceptance uses the pre-edge flags, so push and pop are independent.
    assign push  = en & write & ~full;
    assign pop   = en & read & ~empty;
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    fifo_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (Data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Data_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                Data_out <= rd_word;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (en & write & full);
            underflow <= underflow | (en & read & empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: vector table for fill/drain plus scoreboard-checked sequences.
// Checks overflow/underflow too when FIFO_BUFFER_ERR_FLAGS_EN is defined.
module tb_fifo_buffer;
    import fifo_buffer_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  en = 1'b0;
    logic  write = 1'b0;
    logic  read = 1'b0;
    flit_t Data_in = '0;
    flit_t Data_out;
    logic  empty;
    logic  full;
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    logic  overflow;
    logic  underflow;
`endif

    always #5 clk = ~clk;

    fifo_buffer #(.WIDTH(DEFAULT_WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .write    (write),
        .read     (read),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .empty    (empty),
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .full     (full)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    flit_t sb[$];
    flit_t m_dout = '0;
    logic  m_ovf  = 1'b0;
    logic  m_unf  = 1'b0;

    typedef struct {
        logic  rst;
        logic  en;
        logic  wr;
        logic  rd;
        flit_t din;
        logic  e_empty;
        logic  e_full;
        flit_t e_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare DUT against the model.
    task automatic step(input logic r, input logic e, input logic w, input logic rd_i, input flit_t d);
        logic m_push;
        logic m_pop;
        rst = r; en = e; write = w; read = rd_i; Data_in = d;
        if (r) begin
            sb.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_push = e && w && (sb.size() < DEPTH);
            m_pop  = e && rd_i && (sb.size() > 0);
            if (e && w && sb.size() == DEPTH) m_ovf = 1'b1;
            if (e && rd_i && sb.size() == 0) m_unf = 1'b1;
            if (m_pop) m_dout = sb.pop_front();
            if (m_push) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        check("empty", 32'(empty), 32'(sb.size() == 0));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
        check("data_out", 32'(Data_out), 32'(m_dout));
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // Reset, fill 1..8, drop 9, drain 1..8, read while empty.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
        for (int i = 1; i <= 7; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b1, 8'h00});
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, logic'(i == 8), 1'b0, 8'(i)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h08});

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.rst, v.en, v.wr, v.rd, v.din);
            check("tbl_empty", 32'(empty), 32'(v.e_empty));
            check("tbl_full", 32'(full), 32'(v.e_full));
            check("tbl_dout", 32'(Data_out), 32'(v.e_dout));
        end
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("unf_sticky", 32'(underflow), 32'd1);
`endif

        // Simultaneous push and pop with 3 queued.
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h31);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h32);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
        check("simul_dout", 32'(Data_out), 32'h31);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("simul_not_empty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("simul_aa", 32'(Data_out), 32'hAA);
        check("simul_empty", 32'(empty), 32'd1);

        // Enable gating: requests ignored while frozen.
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h41);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        check("gate_hold", 32'(Data_out), 32'hAA);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("gate_resume", 32'(Data_out), 32'h41);
        check("gate_empty", 32'(empty), 32'd1);

        // Wrap-around ordering.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            check("wrap_dout", 32'(Data_out), 32'(8'h20 + i));
        end

        // Reset mid-operation with en low discards contents.
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h61);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h62);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_dout", 32'(Data_out), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("rst_no_data", 32'(Data_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
